uart_tx_burst: RTL and testbench

UART_TX_BURST -- requirements
Module: uart_tx_burst

---
 rtl/uart_tx_burst.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_burst.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_burst.sv
// uart_tx_burst
// Serialises a burst of up to MAX_BYTES bytes onto a single UART line.
// A burst is requested with tx_sig. The bytes are sent highest latched
// index first, each byte LSB first. Frames follow each other with no idle
// gap between them.
//
// Ports
//   clk        : single clock
//   rst_n      : asynchronous active-low reset
//   tx_sig     : burst start request, sampled at posedge clk
//   tx_data    : MAX_BYTES bytes; byte k sits at bits [8k+7:8k]
//   len        : number of bytes in the burst (clamped to MAX_BYTES)
//   tx_pin_out : serial line, idle high, driven straight from a flop
//   busy       : high while a burst is in progress
//   done       : one-cycle pulse on the edge that ends the burst
//   bytes_left : count of bytes not yet completely sent
module uart_tx_burst #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int MAX_BYTES = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               tx_sig,
  input  logic [8*MAX_BYTES-1:0]             tx_data,
  input  logic [$clog2(MAX_BYTES+1)-1:0]     len,
  output logic                               tx_pin_out,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(MAX_BYTES+1)-1:0]     bytes_left
);

  localparam int LW = $clog2(MAX_BYTES + 1);
  localparam int BW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state_reg;
  logic [BW-1:0]          baud_cnt_reg;
  logic [2:0]             bit_cnt_reg;
  logic [8*MAX_BYTES-1:0] data_reg;
  logic [7:0]             shift_reg;
  logic                   par_reg;

  logic [LW-1:0] len_clamp;
  logic [LW-1:0] first_idx;
  logic [LW-1:0] next_idx;
  logic [7:0]    first_byte;
  logic [7:0]    next_byte;
  logic          bit_end;
  logic          par_bit;

  assign len_clamp  = (len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : len;
  assign first_idx  = len_clamp - LW'(1);
  // Only used when at least two bytes remain, so the index is always valid then.
  assign next_idx   = bytes_left - LW'(2);
  assign first_byte = tx_data[8*int'(first_idx) +: 8];
  assign next_byte  = data_reg[8*int'(next_idx) +: 8];
  assign bit_end    = (baud_cnt_reg == BW'(CLK_DIV - 1));
  // par_reg holds the XOR of every data bit already put on the line.
  assign par_bit    = (PARITY == 1) ? ~par_reg : par_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
      tx_pin_out   <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      bytes_left   <= '0;
    end else begin
      done <= 1'b0;
      // The baud counter runs only during a burst and wraps at every bit boundary.
      if (state_reg != IDLE) begin
        baud_cnt_reg <= bit_end ? '0 : baud_cnt_reg + BW'(1);
      end

      case (state_reg)
        IDLE: begin
          if (tx_sig && (len != '0)) begin
            data_reg     <= tx_data;
            bytes_left   <= len_clamp;
            shift_reg    <= first_byte;
            busy         <= 1'b1;
            tx_pin_out   <= 1'b0;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            state_reg    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            tx_pin_out  <= shift_reg[0];
            par_reg     <= shift_reg[0];
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_cnt_reg <= '0;
            state_reg   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt_reg == 3'(DATA_BITS - 1)) begin
              bit_cnt_reg <= '0;
              if (PARITY != 0) begin
                tx_pin_out <= par_bit;
                state_reg  <= PAR;
              end else begin
                tx_pin_out <= 1'b1;
                state_reg  <= STOP;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              tx_pin_out  <= shift_reg[0];
              par_reg     <= par_reg ^ shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end
          end
        end

        PAR: begin
          if (bit_end) begin
            tx_pin_out  <= 1'b1;
            bit_cnt_reg <= '0;
            state_reg   <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (bit_cnt_reg == 3'(STOP_BITS - 1)) begin
              bit_cnt_reg <= '0;
              if (bytes_left == LW'(1)) begin
                busy       <= 1'b0;
                done       <= 1'b1;
                bytes_left <= '0;
                tx_pin_out <= 1'b1;
                state_reg  <= IDLE;
              end else begin
                // Next frame's start bit begins right away: no idle gap.
                bytes_left <= bytes_left - LW'(1);
                shift_reg  <= next_byte;
                tx_pin_out <= 1'b0;
                state_reg  <= START;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_burst.sv
// tb_uart_tx_burst
// Four DUT copies (CLK_DIV=4, 8 data bits, MAX_BYTES=16):
//   0: no parity, 1 stop    1: even parity, 1 stop
//   2: odd parity, 1 stop   3: no parity, 2 stop
// Bursts come from a vector table. Expected bytes are queued when a burst
// is driven. They are popped as each frame is captured from the line.
module tb_uart_tx_burst;

  localparam int NI = 4;
  localparam int CD = 4;
  localparam int MB = 16;
  localparam int LW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n   [NI];
  logic           tx_sig  [NI];
  logic [127:0]   tx_data [NI];
  logic [LW-1:0]  len     [NI];
  logic           tx_pin  [NI];
  logic           busy    [NI];
  logic           done    [NI];
  logic [LW-1:0]  bl      [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    uart_tx_burst #(
      .CLK_DIV  (CD),
      .DATA_BITS(8),
      .PARITY   ((gi == 1) ? 2 : (gi == 2) ? 1 : 0),
      .STOP_BITS((gi == 3) ? 2 : 1),
      .MAX_BYTES(MB)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[gi]),
      .tx_sig    (tx_sig[gi]),
      .tx_data   (tx_data[gi]),
      .len       (len[gi]),
      .tx_pin_out(tx_pin[gi]),
      .busy      (busy[gi]),
      .done      (done[gi]),
      .bytes_left(bl[gi])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] b;
    int         bl;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int           inst;
    int           len;
    logic [127:0] data;
    bit           repulse;
    bit           chain;
    int           exp_n;
    int           exp_done;
  } vec_t;
  vec_t vecs[9];

  function automatic int par_of(int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction

  function automatic int stop_of(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int flen(int i);
    return 1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i);
  endfunction

  // Line bits of one frame, bit 0 first; unused upper bits read as 1.
  function automatic logic [11:0] exp_frame(logic [7:0] b, int i);
    logic [11:0] f;
    logic x;
    f = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = b[k];
    if (par_of(i) != 0) begin
      x = ^b;
      f[9] = (par_of(i) == 1) ? ~x : x;
    end
    return f;
  endfunction

  task automatic check(input bit ok, input string name, input string got, input string exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, got, exp);
  endtask

  task automatic run_burst(input int inst, input int n_len, input logic [127:0] data,
                           input bit repulse, input bit chained, input bit hold_after,
                           input int exp_n, input int exp_done);
    int fd;
    int idx;
    int done_idx;
    bit busy_ok;
    bit cons;
    logic s [48];
    logic [11:0] obs;
    logic [11:0] efr;
    logic [LW-1:0] bl_seen;
    exp_t e;
    fd = flen(inst) * CD;
    if (!chained) @(negedge clk);
    tx_data[inst] = data;
    len[inst]     = LW'(n_len);
    tx_sig[inst]  = 1'b1;
    for (int k = exp_n - 1; k >= 0; k--) sb_q.push_back('{data[8*k +: 8], k + 1});
    @(negedge clk);
    tx_sig[inst] = 1'b0;
    busy_ok  = 1'b1;
    done_idx = -1;
    idx      = 0;
    for (int j = 0; j < exp_n; j++) begin
      bl_seen = '0;
      for (int k = 0; k < fd; k++) begin
        if (k == 0) bl_seen = bl[inst];
        s[k] = tx_pin[inst];
        if (!busy[inst]) busy_ok = 1'b0;
        if (done[inst] && done_idx < 0) done_idx = idx;
        if (repulse && j == 0 && k == 5) begin
          tx_sig[inst]  = 1'b1;
          tx_data[inst] = ~data;
          len[inst]     = LW'(1);
        end
        if (repulse && j == 0 && k == 6) tx_sig[inst] = 1'b0;
        idx++;
        @(negedge clk);
      end
      obs  = '1;
      cons = 1'b1;
      for (int b = 0; b < flen(inst); b++) begin
        obs[b] = s[b*CD];
        for (int m = 1; m < CD; m++) if (s[b*CD+m] !== s[b*CD]) cons = 1'b0;
      end
      if (sb_q.size() == 0) begin
        check(1'b0, "scoreboard", "empty queue", "pending byte");
      end else begin
        e   = sb_q.pop_front();
        efr = exp_frame(e.b, inst);
        check(cons && (obs === efr), $sformatf("frame i%0d f%0d", inst, j),
              $sformatf("%b steady=%0d", obs, cons), $sformatf("%b steady=1", efr));
        check(bl_seen === LW'(e.bl), $sformatf("bytes_left i%0d f%0d", inst, j),
              $sformatf("%0d", bl_seen), $sformatf("%0d", e.bl));
      end
    end
    for (int w = 0; w < 8 && done_idx < 0; w++) begin
      if (done[inst]) done_idx = idx;
      else begin
        idx++;
        @(negedge clk);
      end
    end
    check(done_idx == exp_done, $sformatf("done_cycle i%0d", inst),
          $sformatf("%0d", done_idx), $sformatf("%0d", exp_done));
    check(busy_ok, $sformatf("busy_during i%0d", inst), $sformatf("%0d", busy_ok), "1");
    check(!busy[inst] && bl[inst] == '0 && tx_pin[inst],
          $sformatf("end_state i%0d", inst),
          $sformatf("busy=%0d bl=%0d line=%0d", busy[inst], bl[inst], tx_pin[inst]),
          "busy=0 bl=0 line=1");
    $display("burst inst=%0d len=%0d frames=%0d done_at=%0d", inst, n_len, exp_n, done_idx);
    if (!hold_after) begin
      @(negedge clk);
      check(!done[inst], $sformatf("done_pulse i%0d", inst), $sformatf("%0d", done[inst]), "0");
    end
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; tx_sig[i] = 1'b0; tx_data[i] = '0; len[i] = '0;
    end
    vecs[0] = '{0, 1,  128'hA5,     1'b0, 1'b0, 1,  40};
    vecs[1] = '{1, 1,  128'hA5,     1'b0, 1'b0, 1,  44};
    vecs[2] = '{2, 1,  128'hA5,     1'b0, 1'b0, 1,  44};
    vecs[3] = '{0, 3,  128'h332211, 1'b0, 1'b0, 3,  120};
    vecs[4] = '{0, 3,  128'h0,      1'b1, 1'b0, 3,  120};
    vecs[5] = '{3, 20, 128'h0,      1'b0, 1'b0, 16, 704};
    vecs[6] = '{0, 16, 128'h0,      1'b0, 1'b0, 16, 640};
    vecs[7] = '{0, 2,  128'h0,      1'b0, 1'b0, 2,  80};
    vecs[8] = '{0, 1,  128'h0,      1'b0, 1'b1, 1,  40};
    for (int v = 4; v < 9; v++)
      vecs[v].data = {$urandom(), $urandom(), $urandom(), $urandom()};

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check(tx_pin[i] && !busy[i] && !done[i] && bl[i] == '0, $sformatf("reset i%0d", i),
            $sformatf("line=%0d busy=%0d done=%0d bl=%0d", tx_pin[i], busy[i], done[i], bl[i]),
            "line=1 busy=0 done=0 bl=0");
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 9; v++)
      run_burst(vecs[v].inst, vecs[v].len, vecs[v].data, vecs[v].repulse, vecs[v].chain,
                (v < 8) ? vecs[v+1].chain : 1'b0, vecs[v].exp_n, vecs[v].exp_done);

    // len = 0 request is ignored
    @(negedge clk);
    len[0] = '0; tx_sig[0] = 1'b1; tx_data[0] = 128'hFF;
    @(negedge clk);
    tx_sig[0] = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (busy[0] || done[0] || !tx_pin[0]) ok = 1'b0;
      @(negedge clk);
    end
    check(ok, "len0_ignored", $sformatf("%0d", ok), "1");
    $display("burst inst=0 len=0 ignored");

    // Reset pulsed during data bit 3
    tx_data[0] = 128'hA5; len[0] = LW'(1); tx_sig[0] = 1'b1;
    @(negedge clk);
    tx_sig[0] = 1'b0;
    repeat (17) @(negedge clk);
    check(!tx_pin[0] && busy[0], "mid_frame_before_reset",
          $sformatf("line=%0d busy=%0d", tx_pin[0], busy[0]), "line=0 busy=1");
    rst_n[0] = 1'b0;
    #1;
    check(tx_pin[0] && !busy[0] && !done[0] && bl[0] == '0, "async_reset",
          $sformatf("line=%0d busy=%0d done=%0d bl=%0d", tx_pin[0], busy[0], done[0], bl[0]),
          "line=1 busy=0 done=0 bl=0");
    @(negedge clk);
    rst_n[0] = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!tx_pin[0] || busy[0]) ok = 1'b0;
    end
    check(ok, "no_resume", $sformatf("%0d", ok), "1");
    $display("reset pulse inst=0 during data bit 3");
    run_burst(0, 1, 128'h3C, 1'b0, 1'b0, 1'b0, 1, 40);

    check(sb_q.size() == 0, "scoreboard_drain", $sformatf("%0d", sb_q.size()), "0");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
